mem_responder: RTL and testbench

Variable-latency data-memory responder serving the load/store port of the 5-stage pipeline. Accepts one word-addressed request at a time over a valid/ready handshake, holds the pipeline with `stall` for a programmable number of cycles, performs the access, then returns a one-cycle response. It replaces the single-cycle data memory so the pipeline can be exercised against realistic memory latency.

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_responder_array.sv | 23 ++
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and default geometry for the variable-latency data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 1024;

endpackage

// File: rtl/mem_responder_if.sv
// Load/store port between the pipeline (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int unsigned ADDR_W = mem_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mem_pkg::DATA_W_DEF
);

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              stall;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, stall, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, stall, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM with registered read; contents are not reset.
module mem_array #(
    parameter int unsigned DEPTH  = mem_pkg::DEPTH_DEF,
    parameter int unsigned DATA_W = mem_pkg::DATA_W_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Variable-latency responder: accept one request, stall for LATENCY cycles,
// access the array, then present a one-cycle response.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned LATENCY = 3
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int unsigned ARR_AW = $clog2(DEPTH);

    state_t            state;
    state_t            nextState;
    logic [3:0]        cnt;
    logic              holdWrite;
    logic [ADDR_W-1:0] holdAddr;
    logic [DATA_W-1:0] holdWdata;
    logic [DATA_W-1:0] respData;
    logic              respErr;
    logic              respFromArray;
    logic [DATA_W-1:0] arrRdata;
    logic              inRange;
    logic              accessNow;
    logic              arrWe;

    assign inRange   = 32'(holdAddr) < DEPTH;
    assign accessNow = (state == WAIT) && (cnt == '0);
    // Gating with rst keeps a store that is still waiting from landing in the array.
    assign arrWe     = accessNow && holdWrite && inRange && !rst;

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arrWe),
        .addr  (holdAddr[ARR_AW-1:0]),
        .wdata (holdWdata),
        .rdata (arrRdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState      = state;
        bus.req_ready  = 1'b0;
        bus.stall      = 1'b0;
        bus.resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                bus.stall = 1'b1;
                if (cnt == '0) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                nextState      = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            holdWrite     <= 1'b0;
            holdAddr      <= '0;
            holdWdata     <= '0;
            respData      <= '0;
            respErr       <= 1'b0;
            respFromArray <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        holdWrite <= bus.req_write;
                        holdAddr  <= bus.req_addr;
                        holdWdata <= bus.req_wdata;
                        cnt       <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        respErr       <= !inRange;
                        respFromArray <= !holdWrite && inRange;
                        respData      <= holdWrite ? holdWdata : '0;
                    end
                end
                RESP: begin
                    // Load data arrives from the array during RESP; latch it so it holds afterwards.
                    if (respFromArray) begin
                        respData      <= arrRdata;
                        respFromArray <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_rdata = respFromArray ? arrRdata : respData;
    assign bus.resp_err   = respErr;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder at LATENCY=3 (dutA) and LATENCY=1 (dutB).
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rstA;
    logic rstB;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    mem_responder_if #(.ADDR_W(16), .DATA_W(32)) busA ();
    mem_responder_if #(.ADDR_W(16), .DATA_W(32)) busB ();

    mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .LATENCY(3)) dutA (
        .clk (clk),
        .rst (rstA),
        .bus (busA.slave)
    );

    mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .LATENCY(1)) dutB (
        .clk (clk),
        .rst (rstB),
        .bus (busB.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        ready;
        logic        stall;
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } obs_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic w, input logic [15:0] a,
                         input logic [31:0] d);
        if (sel == 0) begin
            busA.req_valid = v; busA.req_write = w; busA.req_addr = a; busA.req_wdata = d;
        end else begin
            busB.req_valid = v; busB.req_write = w; busB.req_addr = a; busB.req_wdata = d;
        end
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) o = {busA.req_ready, busA.stall, busA.resp_valid, busA.resp_err, busA.resp_rdata};
        else          o = {busB.req_ready, busB.stall, busB.resp_valid, busB.resp_err, busB.resp_rdata};
        return o;
    endfunction

    task automatic checkResetOutputs(input int sel, input string tag);
        obs_t o;
        o = sample(sel);
        chk({tag, "_ready"}, 32'(o.ready), 32'd0);
        chk({tag, "_stall"}, 32'(o.stall), 32'd0);
        chk({tag, "_valid"}, 32'(o.valid), 32'd0);
        chk({tag, "_rdata"}, o.rdata, 32'd0);
        chk({tag, "_err"},   32'(o.err), 32'd0);
    endtask

    // Called and returns on a negedge in an IDLE cycle; the nxt* request is left on the bus.
    task automatic doReq(input int sel, input int lat, input logic w, input logic [15:0] a,
                         input logic [31:0] d, input logic [31:0] expData, input logic expErr,
                         input logic nxtV, input logic nxtW, input logic [15:0] nxtA,
                         input logic [31:0] nxtD, output int acceptCycle);
        obs_t o;
        exp_t e;
        drive(sel, 1'b1, w, a, d);
        e.data = expData;
        e.err  = expErr;
        sb.push_back(e);
        o = sample(sel);
        chk("ready_idle", 32'(o.ready), 32'd1);
        @(negedge clk);
        acceptCycle = cycle;
        drive(sel, nxtV, nxtW, nxtA, nxtD);
        for (int k = 0; k < lat; k++) begin
            o = sample(sel);
            chk("stall_wait", 32'(o.stall), 32'd1);
            chk("ready_wait", 32'(o.ready), 32'd0);
            chk("valid_wait", 32'(o.valid), 32'd0);
            @(negedge clk);
        end
        o = sample(sel);
        e = sb.pop_front();
        chk("resp_valid", 32'(o.valid), 32'd1);
        chk("stall_resp", 32'(o.stall), 32'd0);
        chk("ready_resp", 32'(o.ready), 32'd0);
        chk("resp_rdata", o.rdata, e.data);
        chk("resp_err",   32'(o.err), 32'(e.err));
        @(negedge clk);
        o = sample(sel);
        chk("valid_oneshot", 32'(o.valid), 32'd0);
        chk("ready_after",   32'(o.ready), 32'd1);
        chk("rdata_hold",    o.rdata, e.data);
        chk("err_hold",      32'(o.err), 32'(e.err));
    endtask

    initial begin
        int t0;
        int t1;
        obs_t o;

        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        rstA = 1'b1;
        rstB = 1'b1;

        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            checkResetOutputs(0, "rstA");
            checkResetOutputs(1, "rstB");
        end
        rstA = 1'b0;
        rstB = 1'b0;
        @(negedge clk);
        o = sample(0);
        chk("post_rst_readyA", 32'(o.ready), 32'd1);
        chk("post_rst_validA", 32'(o.valid), 32'd0);
        o = sample(1);
        chk("post_rst_readyB", 32'(o.ready), 32'd1);
        chk("post_rst_validB", 32'(o.valid), 32'd0);

        // Store then load
        doReq(0, 3, 1'b1, 16'h0010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, t0);
        doReq(0, 3, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, t0);

        // Out of range; 0x0400 aliases 0x0000 in the low address bits
        doReq(0, 3, 1'b1, 16'h0000, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, t0);
        doReq(0, 3, 1'b0, 16'h0400, 32'h0,        32'h00000000, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, t0);
        doReq(0, 3, 1'b1, 16'h0400, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, t0);
        doReq(0, 3, 1'b0, 16'h0000, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, t0);

        // Second request held on the bus through WAIT and RESP
        doReq(0, 3, 1'b1, 16'h0020, 32'h11112222, 32'h11112222, 1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, t0);
        doReq(0, 3, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 16'h0,    32'h0, t1);
        chk("held_req_accept_gap", 32'(t1 - t0), 32'd5);
        doReq(0, 3, 1'b0, 16'h0020, 32'h0,        32'h11112222, 1'b0, 1'b0, 1'b0, 16'h0,    32'h0, t0);

        // Reset during the second WAIT cycle of a store
        doReq(0, 3, 1'b1, 16'h0005, 32'h00000055, 32'h00000055, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, t0);
        drive(0, 1'b1, 1'b1, 16'h0005, 32'h000000AA);
        o = sample(0);
        chk("abort_ready", 32'(o.ready), 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        o = sample(0);
        chk("abort_wait1_stall", 32'(o.stall), 32'd1);
        @(negedge clk);
        o = sample(0);
        chk("abort_wait2_stall", 32'(o.stall), 32'd1);
        rstA = 1'b1;
        @(negedge clk);
        checkResetOutputs(0, "abort_rst");
        rstA = 1'b0;
        repeat (4) begin
            @(negedge clk);
            o = sample(0);
            chk("abort_no_resp", 32'(o.valid), 32'd0);
        end
        doReq(0, 3, 1'b0, 16'h0005, 32'h0, 32'h00000055, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, t0);

        // LATENCY=1 back-to-back stores
        doReq(1, 1, 1'b1, 16'h0030, 32'h0BADCAFE, 32'h0BADCAFE, 1'b0, 1'b1, 1'b1, 16'h0031, 32'h5A5AA5A5, t0);
        doReq(1, 1, 1'b1, 16'h0031, 32'h5A5AA5A5, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0, 16'h0,    32'h0,        t1);
        chk("lat1_accept_gap", 32'(t1 - t0), 32'd3);
        doReq(1, 1, 1'b0, 16'h0030, 32'h0, 32'h0BADCAFE, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, t0);
        doReq(1, 1, 1'b0, 16'h0031, 32'h0, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, t0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
